mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Sequencer that sits directly upstream and downstream of the shift-add multiplier `mult`.
- Accepts operand pairs over a valid/ready handshake, then launches the multiplier with a one-cycle start pulse.
- Waits for the multiplier's busy signal to drop, then sign- or zero-extends the product and adds it into a wrap-around accumulator.
- On the last term of a sequence, presents the accumulated sum over a valid/ready output handshake.

Parameters:
- BW_MCAND, 3, multiplicand width; must match the multiplier instance.
- BW_MLIER, 4, multiplier width; must match the multiplier instance.
- BW_ACC, 10, accumulator width; must be at least BW_MCAND+BW_MLIER.
- BW_N, 4, term-counter width.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_mcand  in  BW_MCAND  multiplicand.
- in_mlier  in  BW_MLIER  multiplier.
- in_mcand_is_signed  in  1  multiplicand is two's complement.
- in_mlier_is_signed  in  1  multiplier is two's complement.
- in_clr  in  1  this term starts a new sum (accumulator treated as 0).
- in_last  in  1  this term ends the sum.
- m_start  out  1  start pulse to the multiplier.
- m_mcand  out  BW_MCAND  registered multiplicand to the multiplier.
- m_mlier  out  BW_MLIER  registered multiplier to the multiplier.
- m_mcand_is_signed  out  1  registered signedness to the multiplier.
- m_mlier_is_signed  out  1  registered signedness to the multiplier.
- m_prod  in  BW_MCAND+BW_MLIER  product from the multiplier.
- m_busy  in  1  multiplier busy.
- out_valid  out  1  accumulated sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_acc  out  BW_ACC  accumulated sum.
- out_n  out  BW_N  number of terms in out_acc (wraps).

Behaviour:
- Reset: asynchronous, active-high, with the reset port named `rst` and all flops clocked on `clk`. While rst is high, all state and outputs are 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately; a partial sum is discarded.
- FSM states: IDLE, START, WAIT, OUT.
- IDLE:
  - in_ready = ~m_busy; in_ready is 0 in every other state.
  - On in_valid & in_ready, latch the operands, both signedness flags, clr and last, then go to START.
- START:
  - m_start = 1 for exactly this one cycle.
  - m_* operand outputs are driven from the registers and held stable until the FSM returns to IDLE.
  - Next state is WAIT.
- WAIT:
  - The multiplier raises m_busy the cycle after m_start and holds it for BW_MLIER cycles.
  - On the first WAIT cycle with m_busy = 0, take m_prod as final and update the accumulator:
    - ext = sign-extend m_prod to BW_ACC if either signedness flag is set, else zero-extend.
    - acc <= (clr ? 0 : acc) + ext, modulo 2^BW_ACC (no saturation).
    - n <= (clr ? 0 : n) + 1, modulo 2^BW_N.
  - Next state: OUT if last, else IDLE.
- OUT:
  - out_valid = 1; out_acc and out_n are stable.
  - On out_ready, go to IDLE. The accumulator keeps its value, so a following term without clr continues the sum.
- Latency: input accept at cycle A → m_start at A+1 → m_busy high A+2..A+1+BW_MLIER → accumulate at A+2+BW_MLIER → out_valid at A+3+BW_MLIER. With defaults that is A+7.
- Throughput: one term per BW_MLIER+3 cycles; no operand overlap.
- Boundary cases:
  - in_valid with m_busy already high in IDLE: not accepted until m_busy falls.
  - in_clr and in_last both set: single-term sum.
  - out_ready held high: OUT lasts exactly one cycle.
  - in_valid during OUT: ignored, no overlap.
- out_acc and out_n reflect the accumulator continuously; they are meaningful only while out_valid is high.

Test Plan:
- Reset: assert rst mid-WAIT → all outputs 0 and in_ready = 1 on the cycle after rst falls; no out_valid follows.
- Unsigned single term: mcand = 7, mlier = 15, clr = 1, last = 1 → out_valid exactly 7 cycles after accept, out_acc = 105, out_n = 1.
- Signed extension: mcand = 3'b100 (signed −4), mlier = 5 (signed) → m_prod = 7'b1101100, out_acc = 10'd1004 (−20).
- Three-term sum with clr on the first term only: (3×4) + (5×6) + (2×7), last on the third → a single out_valid, out_acc = 56, out_n = 3.
- Wrap-around: 10 terms of 7×15 unsigned → out_acc = 1050 mod 1024 = 26, out_n = 10.
- Backpressure: hold out_ready = 0 for 5 cycles → out_valid and out_acc stable, in_ready = 0, in_valid ignored. Separately, with m_busy forced high in IDLE → in_ready = 0 and no m_start.

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq: multiply-accumulate sequencer placed around an external
// shift-add multiplier.
//
// Operand pairs arrive over a valid/ready handshake. Each accepted pair is
// registered, and the multiplier is launched with a one-cycle start pulse.
// When the multiplier's busy signal falls, the product is sign- or
// zero-extended and added into a wrap-around accumulator. On the last term
// of a sequence, the accumulated sum is offered over a valid/ready output
// handshake.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid / in_ready      operand handshake
//   in_mcand, in_mlier       operands
//   in_*_is_signed           operand signedness
//   in_clr, in_last          term starts / ends a sum
//   m_start                  one-cycle start pulse to the multiplier
//   m_mcand, m_mlier         registered operands to the multiplier
//   m_*_is_signed            registered signedness to the multiplier
//   m_prod, m_busy           multiplier product and busy flag
//   out_valid / out_ready    sum handshake
//   out_acc, out_n           accumulated sum and term count
module mac_seq #(
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4,
  parameter int BW_ACC   = 10,
  parameter int BW_N     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BW_MCAND-1:0]          in_mcand,
  input  logic [BW_MLIER-1:0]          in_mlier,
  input  logic                         in_mcand_is_signed,
  input  logic                         in_mlier_is_signed,
  input  logic                         in_clr,
  input  logic                         in_last,
  output logic                         m_start,
  output logic [BW_MCAND-1:0]          m_mcand,
  output logic [BW_MLIER-1:0]          m_mlier,
  output logic                         m_mcand_is_signed,
  output logic                         m_mlier_is_signed,
  input  logic [BW_MCAND+BW_MLIER-1:0] m_prod,
  input  logic                         m_busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BW_ACC-1:0]            out_acc,
  output logic [BW_N-1:0]              out_n
);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [BW_MCAND-1:0]   r_mcand;
  logic [BW_MLIER-1:0]   r_mlier;
  logic                  r_mcand_is_signed;
  logic                  r_mlier_is_signed;
  logic                  r_clr;
  logic                  r_last;
  logic [BW_ACC-1:0]     r_acc;
  logic [BW_N-1:0]       r_n;

  logic                  w_accept;
  logic                  w_done;
  logic [BW_ACC-1:0]     w_ext;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    m_start      = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        // Hold off while the multiplier is still running; also keep ready
        // low during reset so every output reads 0 while rst is high.
        in_ready = ~m_busy & ~rst;
        w_accept = in_valid & ~m_busy;
        if (w_accept) begin
          w_state_next = START;
        end
      end
      START: begin
        m_start      = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        // The multiplier raises busy the cycle after start, so the first
        // WAIT cycle always sees busy high; busy low marks a final product.
        if (!m_busy) begin
          w_done       = 1'b1;
          w_state_next = r_last ? OUT : IDLE;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Sign-extend when either operand is signed; the product is then two's
  // complement. A size cast of a signed value sign-extends.
  assign w_ext = (r_mcand_is_signed | r_mlier_is_signed)
               ? BW_ACC'($signed(m_prod))
               : BW_ACC'(m_prod);

  // Operand capture and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand           <= '0;
      r_mlier           <= '0;
      r_mcand_is_signed <= 1'b0;
      r_mlier_is_signed <= 1'b0;
      r_clr             <= 1'b0;
      r_last            <= 1'b0;
      r_acc             <= '0;
      r_n               <= '0;
    end else begin
      if (w_accept) begin
        r_mcand           <= in_mcand;
        r_mlier           <= in_mlier;
        r_mcand_is_signed <= in_mcand_is_signed;
        r_mlier_is_signed <= in_mlier_is_signed;
        r_clr             <= in_clr;
        r_last            <= in_last;
      end
      if (w_done) begin
        r_acc <= (r_clr ? '0 : r_acc) + w_ext;
        r_n   <= (r_clr ? '0 : r_n) + BW_N'(1);
      end
    end
  end

  // Operand registers only load in IDLE, so these stay stable from START
  // through WAIT and OUT.
  assign m_mcand           = r_mcand;
  assign m_mlier           = r_mlier;
  assign m_mcand_is_signed = r_mcand_is_signed;
  assign m_mlier_is_signed = r_mlier_is_signed;
  assign out_acc           = r_acc;
  assign out_n             = r_n;

endmodule

// File: tb/tb_mac_seq.sv
module tb_mac_seq;
  localparam int BW_MCAND = 3;
  localparam int BW_MLIER = 4;
  localparam int BW_ACC   = 10;
  localparam int BW_N     = 4;
  localparam int BW_PROD  = BW_MCAND + BW_MLIER;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [BW_MCAND-1:0] in_mcand = '0;
  logic [BW_MLIER-1:0] in_mlier = '0;
  logic                in_mcand_is_signed = 1'b0;
  logic                in_mlier_is_signed = 1'b0;
  logic                in_clr = 1'b0;
  logic                in_last = 1'b0;
  logic                m_start;
  logic [BW_MCAND-1:0] m_mcand;
  logic [BW_MLIER-1:0] m_mlier;
  logic                m_mcand_is_signed;
  logic                m_mlier_is_signed;
  logic [BW_PROD-1:0]  m_prod;
  logic                m_busy;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [BW_ACC-1:0]   out_acc;
  logic [BW_N-1:0]     out_n;

  mac_seq #(
    .BW_MCAND(BW_MCAND), .BW_MLIER(BW_MLIER), .BW_ACC(BW_ACC), .BW_N(BW_N)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mlier(in_mlier),
    .in_mcand_is_signed(in_mcand_is_signed), .in_mlier_is_signed(in_mlier_is_signed),
    .in_clr(in_clr), .in_last(in_last),
    .m_start(m_start), .m_mcand(m_mcand), .m_mlier(m_mlier),
    .m_mcand_is_signed(m_mcand_is_signed), .m_mlier_is_signed(m_mlier_is_signed),
    .m_prod(m_prod), .m_busy(m_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_n(out_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;
  int m_acc = 0;
  int m_n = 0;

  typedef struct {
    int acc;
    int n;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Integer value of an operand under its signedness flag
  function automatic int opval(input int raw, input int width, input bit sgn);
    if (sgn && raw >= (1 << (width - 1))) return raw - (1 << width);
    return raw;
  endfunction

  // Behavioural multiplier: busy rises the cycle after start, stays high for
  // BW_MLIER cycles, product is final when busy falls.
  logic mult_busy;
  logic force_busy = 1'b0;
  int   mult_cnt;
  assign m_busy = mult_busy | force_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_busy <= 1'b0;
      mult_cnt  <= 0;
      m_prod    <= '0;
    end else if (m_start) begin
      int p;
      p = opval(int'(m_mcand), BW_MCAND, m_mcand_is_signed)
        * opval(int'(m_mlier), BW_MLIER, m_mlier_is_signed);
      m_prod    <= p[BW_PROD-1:0];
      mult_busy <= 1'b1;
      mult_cnt  <= BW_MLIER;
    end else if (mult_busy) begin
      if (mult_cnt == 1) mult_busy <= 1'b0;
      mult_cnt <= mult_cnt - 1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands over a sum
  logic prev_valid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && !prev_valid)
        check("latency", cyc - last_accept, 7);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got acc %0d n %0d, required no output", out_acc, out_n);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_acc", int'(out_acc), e.acc);
          check("out_n", int'(out_n), e.n);
          $display("sum out: acc=%0d n=%0d expected acc=%0d n=%0d", out_acc, out_n, e.acc, e.n);
        end
      end
      prev_valid = out_valid;
    end
  end

  // Issue one term; updates the reference sum unless upd is 0
  task automatic send(input int mc, input int ml, input bit ms, input bit ls,
                      input bit clr, input bit last, input bit upd);
    int bound;
    @(posedge clk); #1;
    in_mcand = mc[BW_MCAND-1:0];
    in_mlier = ml[BW_MLIER-1:0];
    in_mcand_is_signed = ms;
    in_mlier_is_signed = ls;
    in_clr = clr;
    in_last = last;
    in_valid = 1'b1;
    bound = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      bound++;
      if (bound > 100) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    last_accept = cyc;
    if (upd) begin
      int p;
      p = opval(mc, BW_MCAND, ms) * opval(ml, BW_MLIER, ls);
      m_acc = ((clr ? 0 : m_acc) + p) & ((1 << BW_ACC) - 1);
      m_n   = ((clr ? 0 : m_n) + 1) & ((1 << BW_N) - 1);
      if (last) exp_q.push_back('{acc: m_acc, n: m_n});
    end
    $display("term in: mcand=%0d mlier=%0d s=%0b%0b clr=%0b last=%0b", mc, ml, ms, ls, clr, last);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int bound;
    bound = 0;
    while (exp_q.size() != 0 && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_acc", int'(out_acc), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);

    // Unsigned single term: 7 x 15
    send(7, 15, 0, 0, 1, 1, 1);
    wait_drain();

    // Signed: -4 x 5
    send(4, 5, 1, 1, 1, 1, 1);
    wait_drain();

    // Three-term sum
    send(3, 4, 0, 0, 1, 0, 1);
    send(5, 6, 0, 0, 0, 0, 1);
    send(2, 7, 0, 0, 0, 1, 1);
    wait_drain();

    // Wrap-around: ten terms of 7 x 15
    for (int i = 0; i < 10; i++) send(7, 15, 0, 0, i == 0, i == 9, 1);
    wait_drain();

    // Output backpressure with in_valid ignored during OUT
    out_ready = 1'b0;
    send(6, 9, 0, 0, 1, 1, 1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    in_mcand = 3'd5; in_mlier = 4'd5; in_clr = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_acc", int'(out_acc), m_acc);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_m_start", int'(m_start), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Multiplier busy while IDLE blocks acceptance
    @(posedge clk); #1;
    force_busy = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_in_ready", int'(in_ready), 0);
      check("busy_m_start", int'(m_start), 0);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_release_ready", int'(in_ready), 1);

    // Reset mid-WAIT discards the partial sum
    send(7, 15, 0, 0, 1, 1, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_m_start", int'(m_start), 0);
    check("midrst_m_mcand", int'(m_mcand), 0);
    check("midrst_out_acc", int'(out_acc), 0);
    check("midrst_out_n", int'(out_n), 0);
    @(posedge clk); #2 rst = 1'b0;
    m_acc = 0;
    m_n = 0;
    @(negedge clk);
    check("postrst_in_ready", int'(in_ready), 1);
    repeat (12) @(negedge clk);

    // Randomized terms against the reference sum
    for (int i = 0; i < 40; i++) begin
      bit clr;
      bit last;
      clr  = (i == 0) || ($urandom_range(0, 4) == 0);
      last = (i == 39) || ($urandom_range(0, 2) == 0);
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), clr, last, 1);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
